aes_decrypt_sequencer: RTL
==========================

// Module: aes_decrypt_sequencer
// PURPOSE
//  Sequences the iterative AES inverse-round datapath (one round per clock, external instance) for AES-128/192/256.
//  Accepts one ciphertext+key over a valid/ready handshake and latches both, so they stay stable for the whole run.
//  Drives the datapath round counter and round-count inputs, captures the plaintext on the final round,
//  and returns it over a valid/ready handshake. Sits between the host bus adapter and the round datapath.
// PARAMETERS
//  DATA_W      128    block width
//  KEY_W       256    key bus width; shorter keys are MSB-aligned, i.e. key[255 -: 128] or key[255 -: 192]
//  IDLE_CNT    6'h3F  counter value driven when not running; >= 2*14, so the datapath state register stays frozen
// PORTS
//  clk             in   1       clock, all state on posedge
//  reset           in   1       synchronous, active-high
//  s_valid         in   1       input block offered
//  s_ready         out  1       1 only in IDLE
//  s_data          in   128     ciphertext
//  s_key           in   256     cipher key, MSB-aligned
//  s_key_len       in   2       0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-256
//  m_valid         out  1       plaintext available
//  m_ready         in   1       consumer accepts
//  m_data          out  128     plaintext
//  core_in         out  128     latched ciphertext to datapath
//  core_key        out  256     latched key to datapath
//  core_counter    out  6       round counter to datapath
//  core_max_round  out  6       10/12/14 to datapath
//  core_out        in   128     datapath result (combinational)
//  busy            out  1       1 in RUN or DONE
// BEHAVIOUR
//  Reset values: state=IDLE; m_valid=0; m_data=0; core_in=0; core_key=0; core_counter=IDLE_CNT; core_max_round=10;
//   busy=0. s_ready is 0 while reset is high.
//  The reset check overrides every other transition, including in RUN: the in-flight block is discarded and m_valid drops.
//  FSM:
//   IDLE: s_ready=1. On s_valid the block is accepted:
//    - latch s_data to core_in and s_key to core_key;
//    - maxR = {10,12,14,14}[s_key_len] goes to core_max_round;
//    - core_counter <= maxR; next state RUN.
//   RUN: core_counter increments by 1 each cycle.
//    - When core_counter == 2*maxR: m_data <= core_out, m_valid <= 1, core_counter <= IDLE_CNT; next state DONE.
//   DONE: m_valid held with m_data stable until m_ready is sampled high.
//    - At that edge: m_valid <= 0; next state IDLE.
//    - m_ready high in any other state has no effect.
//  Latency (accept edge counts as edge 0):
//   - core_counter = maxR during cycle 1 and reaches 2*maxR in cycle maxR+1;
//   - m_valid rises after edge maxR+1, i.e. it is high from cycle maxR+2;
//   - that is cycle 12 for AES-128, 14 for AES-192, 16 for AES-256.
//  Throughput: one block per maxR+3 cycles when m_ready is tied high. No overlap: s_ready stays 0 in RUN and DONE.
//  Widths: 2*maxR is computed at 6 bits (max 28, no overflow). core_counter never exceeds 2*maxR, except for IDLE_CNT.
//  core_in, core_key and core_max_round change only on an accept edge (or reset).
//  s_data, s_key and s_key_len are ignored when no accept takes place.
// STRUCTURE
//  Shared package aes_pkg holds:
//   - NR_128=6'd10, NR_192=6'd12, NR_256=6'd14;
//   - the key-length encoding;
//   - the state enum {IDLE, RUN, DONE};
//   - function nr_of_keylen(2b) -> 6b.
//  Single flat module, no sub-module; the datapath is instantiated by the parent, not inside this block.
// TESTING
//  1. FIPS-197 C.1: AES-128, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102..0f.
//     -> m_data 00112233445566778899aabbccddeeff; m_valid first high in cycle 12 after the accept edge.
//  2. FIPS-197 C.2 (AES-192, ct dda97ca4864cdfe06eaf70a0ec0d7191) and C.3 (AES-256, ct 8ea2b7ca516745bfeafc49904b496089).
//     -> same plaintext in both; m_valid high in cycles 14 and 16 respectively.
//  3. Back-pressure: m_ready held 0 for 20 cycles after m_valid rises.
//     -> m_data stable, s_ready=0 throughout; the handshake completes the cycle m_ready=1; s_ready=1 the next cycle.
//  4. s_valid held high through RUN with changed s_data.
//     -> second block accepted only after the DONE handshake; core_in unchanged during RUN; both results correct, in order.
//  5. reset pulsed in cycle 5 of an AES-256 run.
//     -> next cycle: IDLE, m_valid=0, core_counter=6'h3F, busy=0; the following C.1 block decrypts correctly.
//  6. s_key_len=3 with the C.3 vectors.
//     -> core_max_round=14; same plaintext as C.3; m_valid in cycle 16.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES decrypt sequencer: round counts, key-length
// encoding, FSM states and the key-length to round-count mapping.
package aes_pkg;

  localparam logic [5:0] NR_128 = 6'd10;
  localparam logic [5:0] NR_192 = 6'd12;
  localparam logic [5:0] NR_256 = 6'd14;

  typedef enum logic [1:0] {
    KEY_128     = 2'd0,
    KEY_192     = 2'd1,
    KEY_256     = 2'd2,
    KEY_256_ALT = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Encoding 3 is not a real key size and falls back to the AES-256 schedule.
  function automatic logic [5:0] nr_of_keylen(input logic [1:0] key_len);
    logic [5:0] nr;
    case (key_len)
      KEY_128: nr = NR_128;
      KEY_192: nr = NR_192;
      default: nr = NR_256;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_decrypt_sequencer.sv
// Control sequencer for an external one-round-per-clock AES inverse-round datapath:
// latches one block and key, steps the round counter, captures the plaintext.
module aes_decrypt_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned KEY_W    = 256,
  parameter logic [5:0]  IDLE_CNT = 6'h3F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEY_W-1:0]  s_key,
  input  logic [1:0]        s_key_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] core_in,
  output logic [KEY_W-1:0]  core_key,
  output logic [5:0]        core_counter,
  output logic [5:0]        core_max_round,
  input  logic [DATA_W-1:0] core_out,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [DATA_W-1:0]   core_in_q, core_in_d;
  logic [KEY_W-1:0]    core_key_q, core_key_d;
  logic [5:0]          counter_q, counter_d;
  logic [5:0]          max_round_q, max_round_d;
  logic [5:0]          last_cnt_s;

  // Final round index; 2*14 = 28 still fits in six bits.
  assign last_cnt_s = max_round_q + max_round_q;

  // Next-state and datapath-control decode.
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    core_in_d   = core_in_q;
    core_key_d  = core_key_q;
    counter_d   = counter_q;
    max_round_d = max_round_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          core_in_d   = s_data;
          core_key_d  = s_key;
          max_round_d = nr_of_keylen(s_key_len);
          counter_d   = nr_of_keylen(s_key_len);
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (counter_q == last_cnt_s) begin
          m_data_d  = core_out;
          m_valid_d = 1'b1;
          counter_d = IDLE_CNT;
          state_d   = DONE;
        end else begin
          counter_d = counter_q + 6'd1;
        end
      end
      DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end else begin
          m_valid_d = 1'b1;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        counter_d = IDLE_CNT;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      core_in_q   <= '0;
      core_key_q  <= '0;
      counter_q   <= IDLE_CNT;
      max_round_q <= NR_128;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      core_in_q   <= core_in_d;
      core_key_q  <= core_key_d;
      counter_q   <= counter_d;
      max_round_q <= max_round_d;
    end
  end

  assign s_ready        = (state_q == IDLE) && !reset;
  assign busy           = (state_q != IDLE);
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign core_in        = core_in_q;
  assign core_key       = core_key_q;
  assign core_counter   = counter_q;
  assign core_max_round = max_round_q;

endmodule
